uart_tx_serializer: RTL

Downstream consumer of fifo_tx. Pops bytes from the TX FIFO via the next_frame handshake and serializes each one onto the UART line as: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits. When the FIFO stays non-empty, frames go out back-to-back with no idle gap. Sits between fifo_tx and the chip TX pin.

---
 rtl/uart_tx_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a show-ahead TX FIFO and shifts them out as
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits, back-to-back when data is waiting.
`timescale 1ns/1ps
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_uart_tx,
   input  logic       rst_uart_tx_n,
   input  logic       tx_enable,
   input  logic       fifo_tx_status,
   input  logic [7:0] data_in,
   output logic       next_frame,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_next;
   logic [2:0]       r_bit_idx, w_bit_idx_next;
   logic [7:0]       r_shift, w_shift_next;
   logic             r_parity;
   logic             r_tx, w_tx_next;
   logic             r_done, w_done_next;
   logic             r_run;
   logic             w_bit_end;
   logic             w_load_ok;

   assign w_bit_end = (r_baud_cnt == CNT_LAST);
   // r_run keeps the pop strobe quiet while reset is held and for the release edge.
   assign w_load_ok = r_run & tx_enable & fifo_tx_status;

   always_ff @(posedge clk_uart_tx or negedge rst_uart_tx_n) begin
      if (!rst_uart_tx_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
         r_run      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_cnt_next;
         r_bit_idx  <= w_bit_idx_next;
         r_shift    <= w_shift_next;
         r_tx       <= w_tx_next;
         r_done     <= w_done_next;
         r_run      <= 1'b1;
         if (next_frame)
            r_parity <= (^data_in) ^ (PARITY_ODD != 0);
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_baud_cnt_next = w_bit_end ? '0 : r_baud_cnt + 1'b1;
      w_bit_idx_next  = r_bit_idx;
      w_shift_next    = r_shift;
      w_done_next     = 1'b0;
      w_tx_next       = 1'b1;
      next_frame      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_baud_cnt_next = '0;
            if (w_load_ok) begin
               next_frame     = 1'b1;
               w_shift_next   = data_in;
               w_bit_idx_next = '0;
               w_state_next   = S_START;
            end
         end
         S_START: begin
            if (w_bit_end)
               w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_next = '0;
                  w_state_next   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end)
               w_state_next = S_STOP;
         end
         S_STOP: begin
            // r_bit_idx counts stop bits here; the last stop cycle may chain straight into a new frame.
            if (w_bit_end) begin
               if (r_bit_idx == STOP_LAST) begin
                  w_done_next    = 1'b1;
                  w_bit_idx_next = '0;
                  if (w_load_ok) begin
                     next_frame   = 1'b1;
                     w_shift_next = data_in;
                     w_state_next = S_START;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // Line level is registered from the next state so the pin never glitches.
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = r_parity;
         default:  w_tx_next = 1'b1;
      endcase
   end

   assign tx_serial = r_tx;
   assign tx_busy   = (r_state != S_IDLE) | next_frame;
   assign tx_done   = r_done;

endmodule
